// File: rtl/tmds_encoder_pipe.sv
// Pipelined multi-lane DVI TMDS 8b/10b encoder: stage A does transition minimisation,
// stage B does DC balance / control tokens, with an optional output register.
module tmds_encoder_pipe #(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned REG_OUT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  de,
  input  logic [8*NUM_CH-1:0]   data,
  input  logic [2*NUM_CH-1:0]   ctrl,
  output logic                  out_valid,
  output logic [10*NUM_CH-1:0]  tmds
);

  localparam logic [9:0] CtlTok00 = 10'b1101010100;
  localparam logic [9:0] CtlTok01 = 10'b0010101011;
  localparam logic [9:0] CtlTok10 = 10'b0101010100;
  localparam logic [9:0] CtlTok11 = 10'b1010101011;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [8:0] trans_min(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcnt8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Returns {next_cnt[5:0], symbol[9:0]} for one lane.
  function automatic logic [15:0] balance(input logic [8:0] qm, input logic is_de,
                                          input logic [1:0] c, input logic signed [5:0] cnt);
    logic signed [5:0] n1s;
    logic signed [5:0] n0s;
    logic signed [5:0] d10;
    logic signed [5:0] cnt_n;
    logic [9:0]        sym;
    n1s = $signed({2'b00, popcnt8(qm[7:0])});
    n0s = 6'sd8 - n1s;
    d10 = n1s - n0s;
    if (!is_de) begin
      case (c)
        2'b00:   sym = CtlTok00;
        2'b01:   sym = CtlTok01;
        2'b10:   sym = CtlTok10;
        default: sym = CtlTok11;
      endcase
      cnt_n = 6'sd0;
    end else if ((cnt == 6'sd0) || (n1s == n0s)) begin
      sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n = qm[8] ? (cnt + d10) : (cnt - d10);
    end else if ((!cnt[5] && (n1s > n0s)) || (cnt[5] && (n0s > n1s))) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? 6'sd2 : 6'sd0) - d10;
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt + d10 - (qm[8] ? 6'sd0 : 6'sd2);
    end
    return {cnt_n, sym};
  endfunction

  // Stage A
  logic [8:0]          w_qm [NUM_CH];
  logic                r_a_valid;
  logic                r_a_de;
  logic [2*NUM_CH-1:0] r_a_ctrl;
  logic [8:0]          r_a_qm [NUM_CH];

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_qm[k] = trans_min(data[8*k +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_de    <= 1'b0;
      r_a_ctrl  <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_a_qm[k] <= '0;
      end
    end else begin
      r_a_valid <= in_valid;
      r_a_de    <= de;
      r_a_ctrl  <= ctrl;
      for (int k = 0; k < NUM_CH; k++) begin
        r_a_qm[k] <= w_qm[k];
      end
    end
  end

  // Stage B
  logic [15:0]         w_bal [NUM_CH];
  logic                r_b_valid;
  logic [9:0]          r_b_sym [NUM_CH];
  logic signed [5:0]   r_cnt [NUM_CH];
  logic [10*NUM_CH-1:0] w_b_tmds;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_bal[k] = balance(r_a_qm[k], r_a_de, r_a_ctrl[2*k +: 2], r_cnt[k]);
    end
  end

  // Bubbles leave both the symbol and the disparity untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_b_sym[k] <= CtlTok00;
        r_cnt[k]   <= '0;
      end
    end else begin
      r_b_valid <= r_a_valid;
      if (r_a_valid) begin
        for (int k = 0; k < NUM_CH; k++) begin
          r_b_sym[k] <= w_bal[k][9:0];
          r_cnt[k]   <= $signed(w_bal[k][15:10]);
        end
      end
    end
  end

  always_comb begin
    w_b_tmds = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_b_tmds[10*k +: 10] = r_b_sym[k];
    end
  end

  // Output stage
  if (REG_OUT != 0) begin : g_reg_out
    logic                 r_o_valid;
    logic [10*NUM_CH-1:0] r_o_tmds;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_o_valid <= 1'b0;
        r_o_tmds  <= {NUM_CH{CtlTok00}};
      end else begin
        r_o_valid <= r_b_valid;
        r_o_tmds  <= w_b_tmds;
      end
    end

    assign out_valid = r_o_valid;
    assign tmds      = r_o_tmds;
  end else begin : g_wire_out
    assign out_valid = r_b_valid;
    assign tmds      = w_b_tmds;
  end

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Directed and random checks of tmds_encoder_pipe with REG_OUT=1 and REG_OUT=0 side by side.
module tb_tmds_encoder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        de;
  logic [23:0] data;
  logic [5:0]  ctrl;
  logic        ov1;
  logic        ov0;
  logic [29:0] tm1;
  logic [29:0] tm0;

  tmds_encoder_pipe #(.NUM_CH(3), .REG_OUT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .de(de), .data(data), .ctrl(ctrl),
    .out_valid(ov1), .tmds(tm1)
  );

  tmds_encoder_pipe #(.NUM_CH(3), .REG_OUT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .de(de), .data(data), .ctrl(ctrl),
    .out_valid(ov0), .tmds(tm0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        v;
    logic [29:0] tm;
    logic [17:0] cn;
  } ent_t;

  ent_t              pipe [3];
  logic signed [5:0] m_cnt [3];
  logic [9:0]        m_last [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx6(input logic [5:0] c);
    return {{26{c[5]}}, c};
  endfunction

  function automatic logic [9:0] ctl_tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  task automatic enc(input logic [7:0] d, input int cin, output logic [9:0] sym, output int cout);
    int         n1;
    int         n1q;
    int         n0q;
    logic [8:0] q;
    bit         xn;
    n1   = $countones(d);
    xn   = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    n1q  = $countones(q[7:0]);
    n0q  = 8 - n1q;
    if (cin == 0 || n1q == n0q) begin
      sym  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cout = q[8] ? cin + n1q - n0q : cin + n0q - n1q;
    end else if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
      sym  = {1'b1, q[8], ~q[7:0]};
      cout = cin + (q[8] ? 2 : 0) + n0q - n1q;
    end else begin
      sym  = {1'b0, q[8], q[7:0]};
      cout = cin + n1q - n0q - (q[8] ? 0 : 2);
    end
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare at the next negedge.
  task automatic tick(input logic r, input logic v, input logic d_e, input logic [23:0] dd,
                      input logic [5:0] cc);
    ent_t       e;
    logic [9:0] sym;
    int         c;
    rst = r; in_valid = v; de = d_e; data = dd; ctrl = cc;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i]  = '0;
        m_last[i] = 10'h354;
      end
      for (int j = 0; j < 3; j++) pipe[j] = {1'b0, {3{10'h354}}, 18'b0};
    end else begin
      e = '0;
      e.v = v;
      for (int i = 0; i < 3; i++) begin
        if (v) begin
          if (d_e) begin
            enc(dd[8*i +: 8], int'(m_cnt[i]), sym, c);
            m_cnt[i] = 6'(c);
          end else begin
            sym      = ctl_tok(cc[2*i +: 2]);
            m_cnt[i] = '0;
          end
          m_last[i] = sym;
        end
        e.tm[10*i +: 10] = m_last[i];
        e.cn[6*i +: 6]   = m_cnt[i];
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e;
    end
    @(negedge clk);
    chk("ov_r1", {31'b0, ov1}, {31'b0, pipe[2].v});
    chk("tm_r1", {2'b0, tm1}, {2'b0, pipe[2].tm});
    chk("ov_r0", {31'b0, ov0}, {31'b0, pipe[1].v});
    chk("tm_r0", {2'b0, tm0}, {2'b0, pipe[1].tm});
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cnt_r1_l%0d", i), sx6(dut.r_cnt[i]), sx6(pipe[1].cn[6*i +: 6]));
      chk($sformatf("cnt_r0_l%0d", i), sx6(dut0.r_cnt[i]), sx6(pipe[1].cn[6*i +: 6]));
      n_cmp++;
      assert (dut.r_cnt[i] >= -6'sd16 && dut.r_cnt[i] <= 6'sd15) else begin
        n_bad++;
        $error("FAIL cnt_range_l%0d: observed %0d required -16..15", i, dut.r_cnt[i]);
      end
    end
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'($urandom), 24'($urandom), 6'($urandom));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; de = 1'b0; data = '0; ctrl = '0;
    @(negedge clk);

    // Reset with random inputs
    tick(1'b1, 1'b1, 1'($urandom), 24'($urandom), 6'($urandom));
    tick(1'b1, 1'b1, 1'($urandom), 24'($urandom), 6'($urandom));
    chk("rst_ov", {31'b0, ov1}, 32'd0);
    chk("rst_tm", {2'b0, tm1}, {2'b0, {3{10'h354}}});
    chk("rst_ov0", {31'b0, ov0}, 32'd0);
    chk("rst_tm0", {2'b0, tm0}, {2'b0, {3{10'h354}}});
    for (int i = 0; i < 3; i++) chk("rst_cnt", sx6(dut.r_cnt[i]), 32'd0);
    idle(); chk("post_rst_ov", {31'b0, ov1}, 32'd0);
    idle(); chk("post_rst_ov", {31'b0, ov1}, 32'd0);

    // Control tokens on lane0
    tick(1'b0, 1'b1, 1'b0, 24'($urandom), 6'b000000);
    tick(1'b0, 1'b1, 1'b0, 24'($urandom), 6'b000001);
    chk("ctl_r0_00", {22'b0, tm0[9:0]}, 32'h354);
    tick(1'b0, 1'b1, 1'b0, 24'($urandom), 6'b000010);
    chk("ctl_ov", {31'b0, ov1}, 32'd1);
    chk("ctl_00", {22'b0, tm1[9:0]}, 32'h354);
    chk("ctl_r0_01", {22'b0, tm0[9:0]}, 32'h0AB);
    tick(1'b0, 1'b1, 1'b0, 24'($urandom), 6'b000011);
    chk("ctl_01", {22'b0, tm1[9:0]}, 32'h0AB);
    idle(); chk("ctl_10", {22'b0, tm1[9:0]}, 32'h154);
    idle(); chk("ctl_11", {22'b0, tm1[9:0]}, 32'h2AB);
    idle();
    chk("ctl_hold_ov", {31'b0, ov1}, 32'd0);
    chk("ctl_hold_tm", {22'b0, tm1[9:0]}, 32'h2AB);

    // Disparity: two 0x00 words after a control word
    tick(1'b0, 1'b1, 1'b0, 24'($urandom), 6'b000000);
    tick(1'b0, 1'b1, 1'b1, 24'h000000, 6'($urandom));
    tick(1'b0, 1'b1, 1'b1, 24'h000000, 6'($urandom));
    chk("dc_cnt1", sx6(dut.r_cnt[0]), -8);
    idle();
    chk("dc_cnt2", sx6(dut.r_cnt[0]), 2);
    chk("dc_w1", {22'b0, tm1[9:0]}, 32'h100);
    chk("dc_r0_w2", {22'b0, tm0[9:0]}, 32'h3FF);
    idle(); chk("dc_w2", {22'b0, tm1[9:0]}, 32'h3FF);

    // Tie-break at N1==4
    tick(1'b0, 1'b1, 1'b0, 24'($urandom), 6'b000000);
    tick(1'b0, 1'b1, 1'b1, 24'h00000F, 6'($urandom));
    tick(1'b0, 1'b1, 1'b0, 24'($urandom), 6'b000000);
    chk("tb_cnt_0f", sx6(dut.r_cnt[0]), -4);
    tick(1'b0, 1'b1, 1'b1, 24'h0000F0, 6'($urandom));
    chk("tb_0f", {22'b0, tm1[9:0]}, 32'h105);
    idle();
    chk("tb_cnt_f0", sx6(dut.r_cnt[0]), -4);
    chk("tb_r0_f0", {22'b0, tm0[9:0]}, 32'h205);
    idle(); chk("tb_f0", {22'b0, tm1[9:0]}, 32'h205);

    // Bubbles and lane independence
    tick(1'b0, 1'b1, 1'b0, 24'($urandom), 6'b000000);
    tick(1'b0, 1'b1, 1'b1, 24'h5AFF00, 6'($urandom));
    idle(); chk("bub_ov_ctl", {31'b0, ov1}, 32'd1);
    idle();
    chk("bub_ov1", {31'b0, ov1}, 32'd1);
    chk("bub_w1", {2'b0, tm1}, {2'b0, 10'h263, 10'h200, 10'h100});
    tick(1'b0, 1'b1, 1'b1, 24'h5AFF00, 6'($urandom));
    chk("bub_ov2", {31'b0, ov1}, 32'd0);
    chk("bub_hold", {2'b0, tm1}, {2'b0, 10'h263, 10'h200, 10'h100});
    chk("bub_cnt_l0", sx6(dut.r_cnt[0]), -8);
    chk("bub_cnt_l1", sx6(dut.r_cnt[1]), -8);
    idle();
    chk("bub_ov3", {31'b0, ov1}, 32'd0);
    chk("bub_cnt2_l0", sx6(dut.r_cnt[0]), 2);
    chk("bub_cnt2_l1", sx6(dut.r_cnt[1]), -2);
    chk("bub_cnt2_l2", sx6(dut.r_cnt[2]), 0);
    idle();
    chk("bub_ov4", {31'b0, ov1}, 32'd1);
    chk("bub_w2", {2'b0, tm1}, {2'b0, 10'h263, 10'h0FF, 10'h3FF});
    idle(); chk("bub_ov5", {31'b0, ov1}, 32'd0);

    // Random soak with occasional mid-stream resets
    for (int n = 0; n < 4000; n++) begin
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
           24'($urandom), 6'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
